// File: rtl/vector_output_streamer.sv
// rtl/vector_output_streamer.sv - captures whole output vectors into a FIFO and streams them one element per handshake
// Element order is selectable per vector; adds a capture limit, sticky overflow and a drained indication.
module vector_output_streamer #(
  parameter int VECTOR_SIZE  = 6,
  parameter int OUTPUT_WIDTH = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int COUNT_WIDTH  = 18
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                inFlag,
  input  logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0] inData,
  input  logic                                msbFirst,
  input  logic [COUNT_WIDTH-1:0]              captureLimit,
  output logic                                outValid,
  input  logic                                outReady,
  output logic [OUTPUT_WIDTH-1:0]             outData,
  output logic                                outLast,
  output logic                                overflow,
  output logic [COUNT_WIDTH-1:0]              captured,
  output logic [$clog2(FIFO_DEPTH):0]         level,
  output logic                                done
);
  localparam int VW = VECTOR_SIZE * OUTPUT_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int IW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [VW-1:0]           mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [VW-1:0]           vec_q, vec_d;
  logic                    msb_q, msb_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic                    overflow_q, overflow_d;
  logic [COUNT_WIDTH-1:0]  captured_q, captured_d;
  logic                    done_q, done_d;

  logic          limit_hit;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          hs;
  logic          at_last;
  logic [VW-1:0] head;
  logic [IW-1:0] idx_next;

  function automatic logic [OUTPUT_WIDTH-1:0] elem(input logic [VW-1:0] v,
                                                   input logic [IW-1:0] i,
                                                   input logic m);
    int sel;
    sel = m ? (VECTOR_SIZE - 1 - int'(i)) : int'(i);
    return v[sel*OUTPUT_WIDTH +: OUTPUT_WIDTH];
  endfunction

  always_comb begin
    limit_hit = (captureLimit != '0) && (captured_q >= captureLimit);
    fifo_full = (level_q == LW'(FIFO_DEPTH));
    push      = inFlag && !limit_hit && !fifo_full;
    hs        = out_valid_q && outReady;
    at_last   = (idx_q == IW'(VECTOR_SIZE - 1));
    idx_next  = idx_q + IW'(1);
    head      = mem_q[rd_ptr_q];
    // Pop decision uses the pre-push level, so a push into an empty FIFO is never popped the same edge.
    pop       = (level_q != '0) && ((state_q == IDLE) || (hs && at_last));

    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    vec_d       = vec_q;
    msb_d       = msb_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q;
    captured_d  = captured_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (captured_q != '1) begin
        captured_d = captured_q + COUNT_WIDTH'(1);
      end
    end
    if (inFlag && !limit_hit && fifo_full) begin
      overflow_d = 1'b1;
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      vec_d       = head;
      msb_d       = msbFirst;
      idx_d       = '0;
      state_d     = SEND;
      out_valid_d = 1'b1;
      out_data_d  = elem(head, '0, msbFirst);
      out_last_d  = (VECTOR_SIZE == 1);
    end else if ((state_q == SEND) && hs) begin
      if (at_last) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end else begin
        idx_d      = idx_next;
        out_data_d = elem(vec_q, idx_next, msb_q);
        out_last_d = (idx_next == IW'(VECTOR_SIZE - 1));
      end
    end

    level_d = level_q + LW'(push) - LW'(pop);
    done_d  = limit_hit && (level_q == '0) && (state_q == IDLE);
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= inData;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      vec_q       <= '0;
      msb_q       <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
      captured_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      vec_q       <= vec_d;
      msb_q       <= msb_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
      captured_q  <= captured_d;
      done_q      <= done_d;
    end
  end

  assign outValid = out_valid_q;
  assign outData  = out_data_q;
  assign outLast  = out_last_q;
  assign overflow = overflow_q;
  assign captured = captured_q;
  assign level    = level_q;
  assign done     = done_q;
endmodule

// File: tb/tb_vector_output_streamer.sv
// tb/tb_vector_output_streamer.sv - scoreboard bench for vector_output_streamer
// Stimulus queues expected elements; a negedge monitor pops and compares on every handshake.
module tb_vector_output_streamer;
  localparam int CW = 18;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          inFlag = 1'b0;
  logic [47:0]   inData = '0;
  logic          msbFirst = 1'b0;
  logic [CW-1:0] captureLimit = '0;
  logic          outValid;
  logic          outReady = 1'b1;
  logic [7:0]    outData;
  logic          outLast;
  logic          overflow;
  logic [CW-1:0] captured;
  logic [2:0]    level;
  logic          done;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_data[$];
  logic       exp_last[$];

  vector_output_streamer #(
    .VECTOR_SIZE(6), .OUTPUT_WIDTH(8), .FIFO_DEPTH(4), .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .inFlag(inFlag), .inData(inData),
    .msbFirst(msbFirst), .captureLimit(captureLimit), .outValid(outValid),
    .outReady(outReady), .outData(outData), .outLast(outLast),
    .overflow(overflow), .captured(captured), .level(level), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [47:0] mk(input logic [7:0] b);
    logic [47:0] v;
    for (int e = 0; e < 6; e++) v[e*8 +: 8] = b + 8'(e);
    return v;
  endfunction

  task automatic expect_vec(input logic [47:0] v, input logic m);
    for (int e = 0; e < 6; e++) begin
      int sel;
      sel = m ? 5 - e : e;
      exp_data.push_back(v[sel*8 +: 8]);
      exp_last.push_back(e == 5);
    end
  endtask

  task automatic pulse(input logic [47:0] v);
    inData = v;
    inFlag = 1'b1;
    step();
    inFlag = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Monitor: element compare on handshake, plus hold-stability after a stalled cycle.
  initial begin
    logic       stall;
    logic [7:0] stall_data;
    logic       stall_last;
    logic [7:0] ed;
    logic       el;
    stall = 1'b0;
    stall_data = '0;
    stall_last = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", outValid, 1);
          check("hold_data", outData, stall_data);
          check("hold_last", outLast, stall_last);
        end
        if (outValid && outReady) begin
          if (exp_data.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_element: got %0h expected none", outData);
          end else begin
            ed = exp_data.pop_front();
            el = exp_last.pop_front();
            check("elem_data", outData, ed);
            check("elem_last", outLast, el);
          end
        end
        stall = outValid && !outReady;
        stall_data = outData;
        stall_last = outLast;
      end
    end
  end

  initial begin
    // Reset state
    step();
    step();
    check("rst_valid", outValid, 0);
    check("rst_data", outData, 0);
    check("rst_last", outLast, 0);
    check("rst_overflow", overflow, 0);
    check("rst_captured", captured, 0);
    check("rst_level", level, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    step();

    // Basic LSB order and first-element latency
    expect_vec(48'h060504030201, 1'b0);
    pulse(48'h060504030201);
    check("lsb_valid_k", outValid, 0);
    check("lsb_level_k", level, 1);
    step();
    check("lsb_valid_k1", outValid, 1);
    check("lsb_first", outData, 8'h01);
    check("lsb_level_k1", level, 0);
    repeat (8) step();
    check("lsb_captured", captured, 1);
    check("lsb_idle", outValid, 0);

    // MSB order with alternating backpressure
    do_reset();
    msbFirst = 1'b1;
    expect_vec(48'h060504030201, 1'b1);
    pulse(48'h060504030201);
    for (int i = 0; i < 16; i++) begin
      outReady = (i % 2 == 0);
      step();
    end
    outReady = 1'b1;
    msbFirst = 1'b0;
    check("msb_idle", outValid, 0);

    // Overflow: first vector moves to the serializer, four more fill the FIFO, the sixth drops
    do_reset();
    outReady = 1'b0;
    for (int p = 0; p < 6; p++) begin
      if (p < 5) expect_vec(mk(8'(8'h10 * (p + 1))), 1'b0);
      pulse(mk(8'(8'h10 * (p + 1))));
    end
    check("ovf_level", level, 4);
    check("ovf_captured", captured, 5);
    check("ovf_flag", overflow, 1);
    check("ovf_valid", outValid, 1);
    outReady = 1'b1;
    repeat (34) step();
    check("ovf_sticky", overflow, 1);
    check("ovf_drained", level, 0);
    check("ovf_idle", outValid, 0);

    // Back-to-back: 18 elements with no bubble
    do_reset();
    outReady = 1'b0;
    for (int p = 0; p < 3; p++) begin
      expect_vec(mk(8'(8'h70 + 8'h08 * p)), 1'b0);
      pulse(mk(8'(8'h70 + 8'h08 * p)));
    end
    step();
    outReady = 1'b1;
    for (int i = 0; i < 18; i++) begin
      check("b2b_valid", outValid, 1);
      check("b2b_last", outLast, (i % 6 == 5));
      step();
    end
    check("b2b_end", outValid, 0);

    // Capture limit and done
    do_reset();
    captureLimit = 18'd2;
    expect_vec(mk(8'hA0), 1'b0);
    pulse(mk(8'hA0));
    repeat (9) step();
    expect_vec(mk(8'hB0), 1'b0);
    pulse(mk(8'hB0));
    check("lim_done_early", done, 0);
    repeat (7) step();
    check("lim_done_lasths", done, 0);
    check("lim_valid_lasths", outValid, 0);
    step();
    check("lim_done", done, 1);
    step();
    for (int p = 0; p < 3; p++) begin
      pulse(mk(8'(8'hC0 + 8'h10 * p)));
      repeat (9) step();
    end
    check("lim_captured", captured, 2);
    check("lim_overflow", overflow, 0);
    check("lim_done_hold", done, 1);
    captureLimit = 18'd5;
    step();
    check("lim_done_raised", done, 0);
    captureLimit = '0;

    // Reset mid-stream with buffered vectors
    do_reset();
    outReady = 1'b0;
    for (int p = 0; p < 6; p++) pulse(mk(8'(8'h40 + 8'h08 * p)));
    check("mid_overflow_pre", overflow, 1);
    exp_data.push_back(8'h40);
    exp_last.push_back(1'b0);
    exp_data.push_back(8'h41);
    exp_last.push_back(1'b0);
    outReady = 1'b1;
    step();
    step();
    outReady = 1'b0;
    check("mid_elem3", outData, 8'h42);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_valid", outValid, 0);
    check("mid_level", level, 0);
    check("mid_captured", captured, 0);
    check("mid_overflow", overflow, 0);
    check("mid_last", outLast, 0);
    outReady = 1'b1;
    repeat (20) step();
    check("mid_quiet", outValid, 0);
    expect_vec(mk(8'hE0), 1'b0);
    pulse(mk(8'hE0));
    repeat (10) step();
    check("mid_recaptured", captured, 1);

    check("exp_queue_empty", exp_data.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
